lcd_cmd_sequencer: RTL and testbench
====================================

Name: lcd_cmd_sequencer

Overview:
- Downstream consumer of the load/store unit's 32-bit LCD output register; drives a 16x2 HD44780-style character LCD on the board header.
- Turns single CPU stores into correctly timed LCD bus cycles: setup, enable pulse, execution wait.
- Optionally runs the power-up init sequence itself.
- Returns a status word that the load path multiplexes into load data.

Parameters:
- SETUP_CYC, 2, cycles RS/DATA are stable before EN rises (≥1).
- EN_HIGH_CYC, 12, cycles EN is held high (≥1).
- CMD_WAIT_CYC, 2000, cycles after EN falls for a normal command or data write (≥1).
- CLEAR_WAIT_CYC, 82000, wait after clear (0x01) or home (0x02/0x03) commands (≥CMD_WAIT_CYC).
- POWERUP_CYC, 750000, delay after reset before the first init command.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_io_lcd  in  32  LSU LCD register: [31] display power, [30] go-toggle, [9] RS, [7:0] byte.
- o_lcd_data  out  8  LCD data bus.
- o_lcd_rs  out  1  register select.
- o_lcd_rw  out  1  read/write; constant 0.
- o_lcd_en  out  1  enable strobe.
- o_lcd_on  out  1  panel power, = registered i_io_lcd[31].
- o_lcd_status  out  32  [0] busy, [1] init_done, [2] overflow (sticky), [3] pending; [31:4] = 0.

Behaviour:
- Reset (i_reset=0 at an edge) sets all outputs to 0.
  - With LCD_AUTO_INIT_EN: status=0x1 (busy).
  - Without it: status=0x2.
  - Clears the FSM, counters, pending buffer, overflow, and last_toggle (=0).
  - Applies mid-bus-cycle: EN drops on the same edge.
- Command capture:
  - Each cycle, if i_io_lcd[30] != last_toggle, update last_toggle and capture {RS=[9], byte=[7:0]}.
  - Captured command is issued immediately if FSM is IDLE, else stored in the 1-deep pending buffer.
  - If the buffer is already full: drop the new command and set overflow. Overflow clears only on reset.
- o_lcd_on is registered every cycle, independent of the FSM.
- FSM states: PWRUP, INIT, IDLE, SETUP, PULSE, HOLD.
  - PWRUP: count POWERUP_CYC, then go to SETUP with init cmd 0 (0x38).
  - SETUP: drive RS/DATA, EN=0 for SETUP_CYC, then go to PULSE.
  - PULSE: EN=1 for EN_HIGH_CYC, then go to HOLD.
  - HOLD: EN=0 for CLEAR_WAIT_CYC if RS=0 and byte in {0x01,0x02,0x03}, else CMD_WAIT_CYC.
  - After HOLD:
    - Init commands remaining: next init cmd, go to SETUP.
    - Init just finished: set init_done, then as for a command.
    - Pending valid: load it, clear pending, go to SETUP (no IDLE cycle).
    - Otherwise go to IDLE.
  - IDLE: a captured command goes to SETUP on the next edge.
- Init list (RS=0): 0x38, 0x0C, 0x01, 0x06, in that order.
- RS/DATA hold their last values in HOLD and IDLE; they change only on entry to SETUP.
- busy=1 in every state except IDLE; pending reflects buffer valid.
- A toggle during PWRUP/INIT is buffered (pending), executed after init.
- Latency:
  - First EN rise = SETUP_CYC+1 edges after capture from IDLE.
  - EN high exactly EN_HIGH_CYC cycles.
  - Total bus cycle from SETUP entry = SETUP_CYC + EN_HIGH_CYC + wait.
- Counters wide enough for max(POWERUP_CYC, CLEAR_WAIT_CYC); load with N-1 on state entry, advance at 0.

Optional Feature:
- LCD_AUTO_INIT_EN defined: reset enters PWRUP, runs the init list, init_done=1 after the 4th HOLD.
- Not defined: PWRUP/INIT logic is compiled out; reset enters IDLE with init_done=1 and busy=0; software performs init.

Test Plan (SETUP_CYC=2, EN_HIGH_CYC=3, CMD_WAIT_CYC=10, CLEAR_WAIT_CYC=40, POWERUP_CYC=20):
- Init, with LCD_AUTO_INIT_EN: release reset -> EN pulses carry 0x38, 0x0C, 0x01, 0x06 with RS=0, each EN high 3 cycles; gap after 0x01 ≥40 cycles; status=0x2 afterwards.
- Data write: from IDLE, i_io_lcd=0x4000_0241 -> RS=1, DATA=0x41 two cycles before EN; EN high 3 cycles; busy for 15 cycles; then status=0x2.
- Back-to-back: toggle 0x0041, then toggle 0x0042 while busy -> pending=1; second EN pulse starts immediately after the first HOLD; both bytes appear in order; overflow=0.
- Overflow: three toggles within one bus cycle -> third dropped; status[2]=1 persists; only two EN pulses.
- Reset mid-pulse: assert i_reset=0 during PULSE -> EN=0, DATA=0, RS=0 on that edge; pending and overflow cleared; init restarts (with macro).
- Power bit: set i_io_lcd[31]=1 with no toggle change -> o_lcd_on=1 one edge later; no EN activity.

Source files
------------

// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - timed HD44780 bus sequencer fed by the LSU LCD register
//
// Purpose: turns single CPU stores into LCD bus cycles (setup, enable pulse,
// execution wait). It also keeps a one-deep pending buffer and a status word.
// Optional macro LCD_AUTO_INIT_EN: after reset the block waits POWERUP_CYC and
// then issues the init list 0x38, 0x0C, 0x01, 0x06 by itself.
//
// Ports:
//   i_clk         clock, all logic on the rising edge
//   i_reset       synchronous active-low reset
//   i_io_lcd      LSU LCD register: [31] power, [30] go-toggle, [9] RS, [7:0] byte
//   o_lcd_data    LCD data bus
//   o_lcd_rs      register select
//   o_lcd_rw      read/write, always 0 (write only)
//   o_lcd_en      enable strobe
//   o_lcd_on      panel power, registered i_io_lcd[31]
//   o_lcd_status  [0] busy, [1] init_done, [2] overflow, [3] pending
module lcd_cmd_sequencer #(
  parameter int SETUP_CYC      = 2,
  parameter int EN_HIGH_CYC    = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int POWERUP_CYC    = 750000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic [31:0] o_lcd_status
);

  localparam int MAX_CYC = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  // Counters are loaded with N-1 on state entry and the state advances at 0.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] CMD_LD   = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_WAIT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`ifdef LCD_AUTO_INIT_EN
  localparam logic [CW-1:0] PWRUP_LD = CW'(POWERUP_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          tog_q, tog_d;
  logic          iss_q, iss_d;          // command captured in IDLE, starts next edge
  logic [8:0]    iss_cmd_q, iss_cmd_d;  // {RS, byte}
  logic          pend_q, pend_d;
  logic [8:0]    pend_cmd_q, pend_cmd_d;
  logic          ovf_q, ovf_d;
  logic          on_q;
  logic          init_done;

`ifdef LCD_AUTO_INIT_EN
  logic       init_run_q, init_run_d;
  logic [1:0] init_idx_q, init_idx_d;
  logic       init_done_q, init_done_d;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

  logic cnt_zero;
  logic slow_cmd;
  logic toggled;
  logic unused_bits;

  assign cnt_zero    = (cnt_q == '0);
  // Clear and return-home need the long execution wait.
  assign slow_cmd    = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
  assign toggled     = (i_io_lcd[30] != tog_q);
  assign unused_bits = ^{i_io_lcd[29:10], i_io_lcd[8]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rs_d       = rs_q;
    data_d     = data_q;
    tog_d      = tog_q;
    iss_d      = iss_q;
    iss_cmd_d  = iss_cmd_q;
    pend_d     = pend_q;
    pend_cmd_d = pend_cmd_q;
    ovf_d      = ovf_q;
`ifdef LCD_AUTO_INIT_EN
    init_run_d  = init_run_q;
    init_idx_d  = init_idx_q;
    init_done_d = init_done_q;
`endif

    case (state_q)
`ifdef LCD_AUTO_INIT_EN
      S_PWRUP: begin
        if (cnt_zero) begin
          state_d    = S_SETUP;
          cnt_d      = SETUP_LD;
          rs_d       = 1'b0;
          data_d     = init_cmd(2'd0);
          init_run_d = 1'b1;
          init_idx_d = 2'd0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`endif
      S_IDLE: begin
        if (iss_q) begin
          state_d         = S_SETUP;
          cnt_d           = SETUP_LD;
          {rs_d, data_d}  = iss_cmd_q;
          iss_d           = 1'b0;
        end else if (pend_q) begin
          // Reached only when a capture landed in the buffer on the HOLD exit edge.
          state_d         = S_SETUP;
          cnt_d           = SETUP_LD;
          {rs_d, data_d}  = pend_cmd_q;
          pend_d          = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_PULSE;
          cnt_d   = EN_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_PULSE: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = slow_cmd ? CLEAR_LD : CMD_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_ONE;
        end
`ifdef LCD_AUTO_INIT_EN
        else if (init_run_q && (init_idx_q != 2'd3)) begin
          state_d    = S_SETUP;
          cnt_d      = SETUP_LD;
          rs_d       = 1'b0;
          data_d     = init_cmd(init_idx_q + 2'd1);
          init_idx_d = init_idx_q + 2'd1;
        end
`endif
        else begin
`ifdef LCD_AUTO_INIT_EN
          if (init_run_q) begin
            init_run_d  = 1'b0;
            init_done_d = 1'b1;
          end
`endif
          if (pend_q) begin
            state_d        = S_SETUP;
            cnt_d          = SETUP_LD;
            {rs_d, data_d} = pend_cmd_q;
            pend_d         = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Capture runs after the FSM so a buffer slot freed this cycle is reusable.
    if (toggled) begin
      tog_d = i_io_lcd[30];
      if ((state_q == S_IDLE) && !iss_q && !pend_q) begin
        iss_d     = 1'b1;
        iss_cmd_d = {i_io_lcd[9], i_io_lcd[7:0]};
      end else if (!pend_d) begin
        pend_d     = 1'b1;
        pend_cmd_d = {i_io_lcd[9], i_io_lcd[7:0]};
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
`ifdef LCD_AUTO_INIT_EN
      state_q     <= S_PWRUP;
      cnt_q       <= PWRUP_LD;
      init_run_q  <= 1'b0;
      init_idx_q  <= 2'd0;
      init_done_q <= 1'b0;
`else
      state_q     <= S_IDLE;
      cnt_q       <= '0;
`endif
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      tog_q       <= 1'b0;
      iss_q       <= 1'b0;
      iss_cmd_q   <= 9'd0;
      pend_q      <= 1'b0;
      pend_cmd_q  <= 9'd0;
      ovf_q       <= 1'b0;
      on_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
`ifdef LCD_AUTO_INIT_EN
      init_run_q  <= init_run_d;
      init_idx_q  <= init_idx_d;
      init_done_q <= init_done_d;
`endif
      rs_q        <= rs_d;
      data_q      <= data_d;
      tog_q       <= tog_d;
      iss_q       <= iss_d;
      iss_cmd_q   <= iss_cmd_d;
      pend_q      <= pend_d;
      pend_cmd_q  <= pend_cmd_d;
      ovf_q       <= ovf_d;
      on_q        <= i_io_lcd[31];
    end
  end

  assign o_lcd_data   = data_q;
  assign o_lcd_rs     = rs_q;
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_en     = (state_q == S_PULSE);
  assign o_lcd_on     = on_q;
  assign o_lcd_status = {28'd0, pend_q, ovf_q, init_done, (state_q != S_IDLE)};

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb/tb_lcd_cmd_sequencer.sv - directed self-checking bench for lcd_cmd_sequencer
module tb_lcd_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] io = 32'd0;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;
  logic [31:0] o_lcd_status;

  lcd_cmd_sequencer #(
    .SETUP_CYC(2), .EN_HIGH_CYC(3), .CMD_WAIT_CYC(10),
    .CLEAR_WAIT_CYC(40), .POWERUP_CYC(20)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_io_lcd(io),
    .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
    .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on), .o_lcd_status(o_lcd_status)
  );

  always #5 clk = ~clk;

`ifdef LCD_AUTO_INIT_EN
  localparam logic [31:0] RST_STATUS = 32'h1;
`else
  localparam logic [31:0] RST_STATUS = 32'h2;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic tog = 1'b0;
  logic pwr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] ev_byte[$];
  int         ev_rise[$];
  int         ev_fall[$];
  int         busy_cnt = 0;
  logic       en_prev = 1'b0;

  always @(negedge clk) begin
    if (o_lcd_en && !en_prev) begin
      ev_byte.push_back({o_lcd_rs, o_lcd_data});
      ev_rise.push_back(cyc);
    end
    if (!o_lcd_en && en_prev) ev_fall.push_back(cyc);
    en_prev = o_lcd_en;
    if (o_lcd_status[0]) busy_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_mon();
    ev_byte.delete();
    ev_rise.delete();
    ev_fall.delete();
    busy_cnt = 0;
  endtask

  task automatic send(input logic rs, input logic [7:0] b);
    tog = ~tog;
    io  = {pwr, tog, 20'd0, rs, 1'b0, b};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    io = 32'd0;
    step(3);
    n_cmp++; if (o_lcd_status !== RST_STATUS) begin n_bad++; $display("FAIL reset_status: got %h expected %h", o_lcd_status, RST_STATUS); end
    n_cmp++; if (o_lcd_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b expected 0", o_lcd_en); end
    n_cmp++; if (o_lcd_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", o_lcd_data); end
    n_cmp++; if (o_lcd_rs !== 1'b0) begin n_bad++; $display("FAIL reset_rs: got %b expected 0", o_lcd_rs); end
    n_cmp++; if (o_lcd_rw !== 1'b0) begin n_bad++; $display("FAIL reset_rw: got %b expected 0", o_lcd_rw); end
    n_cmp++; if (o_lcd_on !== 1'b0) begin n_bad++; $display("FAIL reset_on: got %b expected 0", o_lcd_on); end
    clr_mon();
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    logic [7:0] exp_b[4];
    exp_b[0] = 8'h38; exp_b[1] = 8'h0C; exp_b[2] = 8'h01; exp_b[3] = 8'h06;
    step(150);
    n_cmp++; if (ev_byte.size() !== 4) begin n_bad++; $display("FAIL init_count: got %0d expected 4", ev_byte.size()); end
    for (int i = 0; i < 4 && i < ev_byte.size() && i < ev_fall.size(); i++) begin
      n_cmp++; if (ev_byte[i] !== {1'b0, exp_b[i]}) begin n_bad++; $display("FAIL init_byte%0d: got %h expected %h", i, ev_byte[i], {1'b0, exp_b[i]}); end
      n_cmp++; if (ev_fall[i] - ev_rise[i] !== 3) begin n_bad++; $display("FAIL init_en_len%0d: got %0d expected 3", i, ev_fall[i] - ev_rise[i]); end
    end
    if (ev_rise.size() >= 4 && ev_fall.size() >= 3) begin
      n_cmp++; if (!(ev_rise[3] - ev_fall[2] >= 40)) begin n_bad++; $display("FAIL init_clear_gap: got %0d expected >=40", ev_rise[3] - ev_fall[2]); end
    end
    n_cmp++; if (o_lcd_status !== 32'h2) begin n_bad++; $display("FAIL init_status: got %h expected 2", o_lcd_status); end
  endtask

  task automatic test_data_write();
    int c0;
    step(1);
    clr_mon();
    c0 = cyc;
    send(1'b1, 8'h41);
    step(2);
    n_cmp++; if ({o_lcd_rs, o_lcd_data} !== 9'h141) begin n_bad++; $display("FAIL dw_setup_bus: got %h expected 141", {o_lcd_rs, o_lcd_data}); end
    n_cmp++; if (o_lcd_en !== 1'b0) begin n_bad++; $display("FAIL dw_setup_en: got %b expected 0", o_lcd_en); end
    n_cmp++; if (o_lcd_status !== 32'h3) begin n_bad++; $display("FAIL dw_busy_status: got %h expected 3", o_lcd_status); end
    step(20);
    n_cmp++; if (ev_rise.size() !== 1) begin n_bad++; $display("FAIL dw_pulses: got %0d expected 1", ev_rise.size()); end
    if (ev_rise.size() >= 1 && ev_fall.size() >= 1) begin
      n_cmp++; if (ev_rise[0] - c0 !== 4) begin n_bad++; $display("FAIL dw_rise_lat: got %0d expected 4", ev_rise[0] - c0); end
      n_cmp++; if (ev_fall[0] - ev_rise[0] !== 3) begin n_bad++; $display("FAIL dw_en_len: got %0d expected 3", ev_fall[0] - ev_rise[0]); end
    end
    n_cmp++; if (busy_cnt !== 15) begin n_bad++; $display("FAIL dw_busy_cycles: got %0d expected 15", busy_cnt); end
    n_cmp++; if (o_lcd_status !== 32'h2) begin n_bad++; $display("FAIL dw_end_status: got %h expected 2", o_lcd_status); end
    n_cmp++; if ({o_lcd_rs, o_lcd_data} !== 9'h141) begin n_bad++; $display("FAIL dw_idle_hold: got %h expected 141", {o_lcd_rs, o_lcd_data}); end
  endtask

  task automatic test_back_to_back();
    int c0;
    clr_mon();
    c0 = cyc;
    send(1'b0, 8'h41);
    step(3);
    send(1'b0, 8'h42);
    step(1);
    n_cmp++; if (o_lcd_status[3] !== 1'b1) begin n_bad++; $display("FAIL b2b_pending: got %b expected 1", o_lcd_status[3]); end
    step(35);
    n_cmp++; if (ev_byte.size() !== 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d expected 2", ev_byte.size()); end
    if (ev_byte.size() >= 2 && ev_fall.size() >= 1) begin
      n_cmp++; if (ev_byte[0] !== 9'h041) begin n_bad++; $display("FAIL b2b_first: got %h expected 041", ev_byte[0]); end
      n_cmp++; if (ev_byte[1] !== 9'h042) begin n_bad++; $display("FAIL b2b_second: got %h expected 042", ev_byte[1]); end
      n_cmp++; if (ev_rise[0] - c0 !== 4) begin n_bad++; $display("FAIL b2b_rise_lat: got %0d expected 4", ev_rise[0] - c0); end
      n_cmp++; if (ev_rise[1] - ev_fall[0] !== 12) begin n_bad++; $display("FAIL b2b_gap: got %0d expected 12", ev_rise[1] - ev_fall[0]); end
    end
    n_cmp++; if (o_lcd_status !== 32'h2) begin n_bad++; $display("FAIL b2b_end_status: got %h expected 2", o_lcd_status); end
  endtask

  task automatic test_overflow();
    clr_mon();
    send(1'b0, 8'h61);
    step(2);
    send(1'b0, 8'h62);
    step(2);
    send(1'b0, 8'h63);
    step(1);
    n_cmp++; if (o_lcd_status[2] !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b expected 1", o_lcd_status[2]); end
    step(40);
    n_cmp++; if (ev_byte.size() !== 2) begin n_bad++; $display("FAIL ovf_pulses: got %0d expected 2", ev_byte.size()); end
    if (ev_byte.size() >= 2) begin
      n_cmp++; if (ev_byte[0] !== 9'h061) begin n_bad++; $display("FAIL ovf_first: got %h expected 061", ev_byte[0]); end
      n_cmp++; if (ev_byte[1] !== 9'h062) begin n_bad++; $display("FAIL ovf_second: got %h expected 062", ev_byte[1]); end
    end
    n_cmp++; if (o_lcd_status !== 32'h6) begin n_bad++; $display("FAIL ovf_end_status: got %h expected 6", o_lcd_status); end
  endtask

  task automatic test_power_bit();
    clr_mon();
    pwr = 1'b1;
    io  = {pwr, io[30:0]};
    step(1);
    n_cmp++; if (o_lcd_on !== 1'b1) begin n_bad++; $display("FAIL pwr_on: got %b expected 1", o_lcd_on); end
    step(10);
    n_cmp++; if (ev_byte.size() !== 0) begin n_bad++; $display("FAIL pwr_no_en: got %0d expected 0", ev_byte.size()); end
    n_cmp++; if (o_lcd_status !== 32'h6) begin n_bad++; $display("FAIL pwr_ovf_sticky: got %h expected 6", o_lcd_status); end
  endtask

  task automatic test_reset_mid_pulse();
    int k;
    clr_mon();
    send(1'b0, 8'h55);
    step(2);
    send(1'b0, 8'h66);
    k = 0;
    while (o_lcd_en !== 1'b1 && k < 30) begin
      step(1);
      k++;
    end
    n_cmp++; if (o_lcd_en !== 1'b1) begin n_bad++; $display("FAIL mid_reach_pulse: got %b expected 1", o_lcd_en); end
    rst_n = 1'b0;
    tog = 1'b0;
    pwr = 1'b0;
    io  = 32'd0;
    step(1);
    n_cmp++; if (o_lcd_en !== 1'b0) begin n_bad++; $display("FAIL mid_en: got %b expected 0", o_lcd_en); end
    n_cmp++; if (o_lcd_data !== 8'h00) begin n_bad++; $display("FAIL mid_data: got %h expected 00", o_lcd_data); end
    n_cmp++; if (o_lcd_rs !== 1'b0) begin n_bad++; $display("FAIL mid_rs: got %b expected 0", o_lcd_rs); end
    n_cmp++; if (o_lcd_on !== 1'b0) begin n_bad++; $display("FAIL mid_on: got %b expected 0", o_lcd_on); end
    n_cmp++; if (o_lcd_status !== RST_STATUS) begin n_bad++; $display("FAIL mid_status: got %h expected %h", o_lcd_status, RST_STATUS); end
    step(2);
    rst_n = 1'b1;
`ifdef LCD_AUTO_INIT_EN
    step(150);
    n_cmp++; if (ev_byte.size() !== 5) begin n_bad++; $display("FAIL mid_restart_pulses: got %0d expected 5", ev_byte.size()); end
    if (ev_byte.size() >= 2) begin
      n_cmp++; if (ev_byte[1] !== 9'h038) begin n_bad++; $display("FAIL mid_restart_first: got %h expected 038", ev_byte[1]); end
    end
`else
    step(30);
    n_cmp++; if (ev_byte.size() !== 1) begin n_bad++; $display("FAIL mid_no_more_pulses: got %0d expected 1", ev_byte.size()); end
`endif
    n_cmp++; if (o_lcd_status !== 32'h2) begin n_bad++; $display("FAIL mid_end_status: got %h expected 2", o_lcd_status); end
  endtask

  initial begin
    test_reset();
`ifdef LCD_AUTO_INIT_EN
    test_init();
`else
    step(2);
    n_cmp++; if (o_lcd_status !== 32'h2) begin n_bad++; $display("FAIL idle_status: got %h expected 2", o_lcd_status); end
`endif
    test_data_write();
    test_back_to_back();
    test_overflow();
    test_power_bit();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
